// File: rtl/id_stage_reg_pkg.sv
// Shared MIPS definitions: opcode constants, extender select encodings and the NOP word.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic {
    EXT_ZERO = 1'b0,
    EXT_SIGN = 1'b1
  } ext_mode_e;

  // sll $0,$0,0
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/id_stage_reg_ext_sel.sv
// Opcode decoder producing the extender select and a raw (unqualified) illegal flag.
module ext_sel_decode
  import mips_defs::*;
(
  input  logic [5:0] opcode,
  output logic       ext_sign,
  output logic       illegal_raw
);

  ext_mode_e w_mode;

  always_comb begin
    w_mode      = EXT_SIGN;
    illegal_raw = 1'b0;
    case (opcode)
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: w_mode = EXT_ZERO;
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE,
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_LW, OP_SW:                     w_mode = EXT_SIGN;
      default:                          illegal_raw = 1'b1;
    endcase
  end

  assign ext_sign = w_mode;

endmodule

// File: rtl/id_stage_reg.sv
// IF/ID pipeline register with stall/flush control and combinational field decode.
module id_stage_reg #(
  parameter int          PC_W     = 32,
  parameter logic [31:0] NOP_WORD = mips_defs::NOP_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr_in,
  input  logic [PC_W-1:0] pc4_in,
  input  logic            stall,
  input  logic            flush,
  output logic            out_valid,
  output logic [31:0]     instr_q,
  output logic [PC_W-1:0] pc4_q,
  output logic [5:0]      opcode,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [4:0]      shamt,
  output logic [5:0]      funct,
  output logic [15:0]     imm16,
  output logic            ext_sign,
  output logic            illegal
);

  logic [31:0]     r_instr;
  logic [PC_W-1:0] r_pc4;
  logic            r_valid;
  logic            w_illegal_raw;

  // Ready must not look at in_valid, otherwise fetch and this stage form a loop.
  assign in_ready = !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr <= NOP_WORD;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (flush) begin
      r_instr <= NOP_WORD;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (!stall) begin
      if (in_valid) begin
        r_instr <= instr_in;
        r_pc4   <= pc4_in;
        r_valid <= 1'b1;
      end else begin
        r_instr <= NOP_WORD;
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign instr_q   = r_instr;
  assign pc4_q     = r_pc4;
  assign opcode    = r_instr[31:26];
  assign rs        = r_instr[25:21];
  assign rt        = r_instr[20:16];
  assign rd        = r_instr[15:11];
  assign shamt     = r_instr[10:6];
  assign funct     = r_instr[5:0];
  assign imm16     = r_instr[15:0];

  ext_sel_decode u_ext_sel (
    .opcode      (r_instr[31:26]),
    .ext_sign    (ext_sign),
    .illegal_raw (w_illegal_raw)
  );

  assign illegal = r_valid && w_illegal_raw;

endmodule

// File: tb/tb_id_stage_reg.sv
// Directed plus randomized bench for id_stage_reg against a register-transfer reference model.
module tb_id_stage_reg;

  localparam int PC_W = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr_in;
  logic [PC_W-1:0] pc4_in;
  logic            stall;
  logic            flush;
  logic            out_valid;
  logic [31:0]     instr_q;
  logic [PC_W-1:0] pc4_q;
  logic [5:0]      opcode;
  logic [4:0]      rs, rt, rd, shamt;
  logic [5:0]      funct;
  logic [15:0]     imm16;
  logic            ext_sign;
  logic            illegal;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  bit          m_valid;

  id_stage_reg #(.PC_W(PC_W), .NOP_WORD(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr_in(instr_in), .pc4_in(pc4_in), .stall(stall), .flush(flush),
    .out_valid(out_valid), .instr_q(instr_q), .pc4_q(pc4_q),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm16(imm16), .ext_sign(ext_sign), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic bit zero_ext_op(int op);
    return op inside {12, 13, 14, 15};
  endfunction

  function automatic bit legal_op(int op);
    return op inside {0, 2, 3, 4, 5, [8:15], 35, 43};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    int op;
    op = int'(m_instr / 32'h0400_0000);
    chk({tag, ":out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ":instr_q"},   instr_q, m_instr);
    chk({tag, ":pc4_q"},     pc4_q, m_pc4);
    chk({tag, ":opcode"},    32'(opcode), 32'(op));
    chk({tag, ":rs"},        32'(rs),    (m_instr / 32'h20_0000) % 32);
    chk({tag, ":rt"},        32'(rt),    (m_instr / 32'h1_0000) % 32);
    chk({tag, ":rd"},        32'(rd),    (m_instr / 32'h800) % 32);
    chk({tag, ":shamt"},     32'(shamt), (m_instr / 64) % 32);
    chk({tag, ":funct"},     32'(funct), m_instr % 64);
    chk({tag, ":imm16"},     32'(imm16), m_instr % 65536);
    chk({tag, ":ext_sign"},  32'(ext_sign), 32'(!zero_ext_op(op)));
    chk({tag, ":illegal"},   32'(illegal), 32'(m_valid && !legal_op(op)));
  endtask

  task automatic model_reset();
    m_instr = 32'h0;
    m_pc4   = 32'h0;
    m_valid = 1'b0;
  endtask

  // one clock of stimulus; inputs change 1 time unit after the sampling point
  task automatic cycle(string tag, bit v, bit s, bit f, logic [31:0] w, logic [31:0] p);
    in_valid = v; stall = s; flush = f; instr_in = w; pc4_in = p;
    #1;
    chk({tag, ":in_ready"}, 32'(in_ready), 32'(!s));
    @(posedge clk);
    if (f) begin
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else if (!s) begin
      if (v) begin
        m_instr = w; m_pc4 = p; m_valid = 1'b1;
      end else begin
        m_instr = 32'h0; m_valid = 1'b0;
      end
    end
    #1;
    check_all(tag);
    $display("%s v=%0b s=%0b f=%0b in=%h -> valid=%0b instr_q=%h pc4_q=%h", tag, v, s, f, w,
             out_valid, instr_q, pc4_q);
  endtask

  initial begin
    logic [31:0] held_instr, held_pc4, ext32, w;
    logic [5:0]  ops [15];
    ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};

    rst = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    instr_in = 32'h0; pc4_in = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    cycle("accept_ori", 1, 0, 0, 32'h3508_ABCD, 32'h0000_0104);
    chk("ori:opcode", 32'(opcode), 32'h0D);
    chk("ori:rs", 32'(rs), 32'd8);
    chk("ori:rt", 32'(rt), 32'd8);
    chk("ori:imm16", 32'(imm16), 32'hABCD);
    chk("ori:ext_sign", 32'(ext_sign), 32'd0);

    cycle("accept_addi", 1, 0, 0, 32'h2109_FFFC, 32'h0000_0108);
    ext32 = {{16{ext_sign & imm16[15]}}, imm16};
    chk("addi:extended", ext32, 32'hFFFF_FFFC);

    held_instr = instr_q;
    held_pc4   = pc4_q;
    for (int i = 0; i < 3; i++) begin
      cycle("stall", 1, 1, 0, 32'h0100_0000 * i + 32'h8C00_0010, 32'h200 + i);
      chk("stall:instr_hold", instr_q, held_instr);
      chk("stall:pc4_hold", pc4_q, held_pc4);
    end
    cycle("stall_release", 1, 0, 0, 32'hAC22_0004, 32'h0000_010C);
    chk("release:captured", instr_q, 32'hAC22_0004);

    cycle("flush_stall", 1, 1, 1, 32'h1085_0003, 32'h0000_0110);
    chk("flush:valid", 32'(out_valid), 32'd0);
    chk("flush:instr_nop", instr_q, 32'h0);

    cycle("illegal_accept", 1, 0, 0, 32'hFC00_1234, 32'h0000_0114);
    chk("illegal:flag", 32'(illegal), 32'd1);
    cycle("bubble", 0, 0, 0, 32'hFC00_1234, 32'h0000_0118);
    chk("bubble:illegal", 32'(illegal), 32'd0);
    chk("bubble:pc4_hold", pc4_q, 32'h0000_0114);

    cycle("pre_reset", 1, 1, 0, 32'h2409_0001, 32'h0000_0118);
    cycle("pre_reset2", 1, 1, 0, 32'h2409_0001, 32'h0000_0118);
    cycle("pre_reset3", 1, 0, 0, 32'h2409_0001, 32'h0000_0118);
    stall = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    #1;
    rst = 1'b0;
    stall = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 400; n++) begin
      bit v, s, f;
      v = ($urandom_range(0, 9) < 7);
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 9) == 0);
      w = $urandom();
      if ($urandom_range(0, 1) == 1)
        w[31:26] = ops[$urandom_range(0, 14)];
      cycle("rand", v, s, f, w, $urandom());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_stage_reg.md
Name: id_stage_reg

Overview:
IF/ID pipeline register plus field decoder for the MIPS datapath. It captures the fetched instruction and PC+4, then presents the decoded fields to the decode stage. These fields are opcode, rs, rt, rd, shamt, funct, the 16-bit immediate, and the extension-mode select. The immediate and select drive the 16→32 sign/zero extender directly. Handles stall, flush and a valid/ready handshake toward fetch.

Parameters:
- PC_W, 32, width of the PC+4 path
- NOP_WORD, 32'h0000_0000, instruction word loaded on flush or reset (sll $0,$0,0)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  fetch presents a valid instruction this cycle
- in_ready  out  1  stage can accept; combinational, equals !stall
- instr_in  in  32  fetched instruction word
- pc4_in  in  PC_W  PC+4 of the fetched instruction
- stall  in  1  hazard unit holds this stage
- flush  in  1  branch/jump taken; squash the held instruction
- out_valid  out  1  registered instruction is valid
- instr_q  out  32  held instruction word
- pc4_q  out  PC_W  held PC+4
- opcode  out  6  instr_q[31:26]
- rs  out  5  instr_q[25:21]
- rt  out  5  instr_q[20:16]
- rd  out  5  instr_q[15:11]
- shamt  out  5  instr_q[10:6]
- funct  out  6  instr_q[5:0]
- imm16  out  16  instr_q[15:0], feeds extender A
- ext_sign  out  1  extender select: 0 = zero-extend, 1 = sign-extend
- illegal  out  1  opcode not in supported set, qualified by out_valid

Behaviour:
- Reset (async, rst=1): out_valid=0, instr_q=NOP_WORD, pc4_q=0. All decoded outputs follow NOP_WORD, so ext_sign=1 and illegal=0. Takes effect immediately, independent of clk, including mid-stall.
- Per rising edge, with rst=0, the priority order is:
  1. flush=1: instr_q←NOP_WORD, pc4_q←0, out_valid←0. Flush overrides stall and in_valid.
  2. stall=1: all registers hold.
  3. in_valid=1 (accept): instr_q←instr_in, pc4_q←pc4_in, out_valid←1.
  4. in_valid=0 (bubble): instr_q←NOP_WORD, out_valid←0, pc4_q holds.
- Handshake:
  - A transfer occurs when in_valid && in_ready && !flush.
  - in_ready=!stall, with no dependence on in_valid; this avoids a comb loop.
  - Fetch holds instr_in/pc4_in stable while in_valid && !in_ready.
  - If flush and stall are both 1, the instruction offered by fetch that cycle is dropped, not accepted; fetch redirects.
- Latency: 1 cycle from accept to the fields appearing on the outputs. Field outputs are pure slices of instr_q, with no extra register.
- ext_sign is a combinational function of opcode (instr_q[31:26]):
  - 0 for ANDI 0x0C, ORI 0x0D, XORI 0x0E, LUI 0x0F.
  - 1 for every other opcode, including R-type 0x00, ADDI 0x08, ADDIU 0x09, SLTI 0x0A, SLTIU 0x0B, BEQ 0x04, BNE 0x05, LW 0x23 and SW 0x2B.
- illegal=out_valid && opcode ∉ {0x00, 0x02, 0x03, 0x04, 0x05, 0x08–0x0F, 0x23, 0x2B}. illegal is forced to 0 when out_valid=0.
- No wrap or overflow arithmetic happens in this block. pc4 is passed through unmodified.

Decomposition:
- Shared package mips_defs holds:
  - 6-bit opcode constants: OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW.
  - The EXT_ZERO=0 and EXT_SIGN=1 encodings, so they match the extender select.
  - The NOP_WORD constant.
- One combinational sub-module, ext_sel_decode (opcode → ext_sign, illegal_raw). The top ANDs illegal_raw with out_valid.

Test Plan:
- Reset: rst pulsed mid-cycle with a valid instruction held → out_valid=0, instr_q=0, ext_sign=1 immediately, without waiting for a clock edge.
- Accept ORI: instr_in=32'h3508_ABCD, in_valid=1 → next cycle opcode=0x0D, rs=8, rt=8, imm16=0xABCD, ext_sign=0, out_valid=1, illegal=0.
- Accept ADDI: instr_in=32'h2109_FFFC → imm16=0xFFFC, ext_sign=1. Chained into the extender, this gives 32'hFFFF_FFFC.
- Stall: hold stall=1 for 3 cycles while instr_in changes → in_ready=0, instr_q and pc4_q unchanged for all 3 cycles. Release → the new word is captured the next cycle.
- Flush+stall together with in_valid=1 → out_valid=0 and instr_q=NOP_WORD next cycle, and the offered word is not captured.
- Illegal: accept opcode 0x3F → illegal=1. Next cycle in_valid=0 → out_valid=0 and illegal=0.
